ultra_ping_scheduler: RTL and testbench

ULTRA_PING_SCHEDULER -- requirements
Module: ultra_ping_scheduler

---
 rtl/ultra_pkg.sv | 14 +
 rtl/us_tick_gen.sv | 27 ++
 rtl/ultra_ping_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ultra_ping_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ultra_pkg.sv
// Shared types and constants for the ultrasonic ping scheduler.
package ultra_pkg;

  localparam int unsigned RESULT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } ping_state_t;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler; restart realigns the tick phase to a state entry.
module us_tick_gen #(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ultra_ping_scheduler.sv
// Round-robin ultrasonic ranging scheduler: trigger, echo-width measurement, holdoff.
module ultra_ping_scheduler
  import ultra_pkg::*;
#(
  parameter int unsigned N_SENSORS       = 4,
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned ECHO_TIMEOUT_US = 30000,
  parameter int unsigned HOLDOFF_US      = 60000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENSORS-1:0] enable_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trigger,
  input  logic [1:0]           rd_sel,
  output logic [RESULT_W-1:0]  rd_data,
  output logic [1:0]           rd_status,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned US_DIV = CLK_HZ / 1_000_000;
  localparam int unsigned IDX_W  = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  localparam logic [RESULT_W-1:0] TRIG_LAST = RESULT_W'(TRIG_US - 1);
  localparam logic [RESULT_W-1:0] TMO_LAST  = RESULT_W'(ECHO_TIMEOUT_US - 1);
  localparam logic [RESULT_W-1:0] HOLD_LAST = RESULT_W'(HOLDOFF_US - 1);

  ping_state_t state, state_next;

  logic [IDX_W-1:0]    cur, last_idx, rr_pick, sel_idx;
  logic                rr_found;
  logic [RESULT_W-1:0] us_cnt;
  logic [N_SENSORS-1:0] echo_meta, echo_sync, echo_prev;
  logic [N_SENSORS-1:0] trig_vec;
  logic                tick, restart;
  logic                echo_rise, echo_fall;
  logic                rec_en, rec_to;
  logic [RESULT_W-1:0] rec_val;

  logic [RESULT_W-1:0]  result [N_SENSORS];
  logic [N_SENSORS-1:0] valid, tmo;

  assign restart   = (state_next != state);
  assign echo_rise = echo_sync[cur] & ~echo_prev[cur];
  assign echo_fall = ~echo_sync[cur] & echo_prev[cur];

  us_tick_gen #(
    .DIV (US_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick_c  (tick)
  );

  // First enabled sensor strictly after the last one served, wrapping.
  always_comb begin
    int s;
    rr_found = 1'b0;
    rr_pick  = last_idx;
    for (int k = 1; k <= int'(N_SENSORS); k++) begin
      s = int'(last_idx) + k;
      if (s >= int'(N_SENSORS)) s = s - int'(N_SENSORS);
      if (!rr_found && enable_mask[IDX_W'(s)]) begin
        rr_found = 1'b1;
        rr_pick  = IDX_W'(s);
      end
    end
  end

  always_comb begin
    sel_idx           = (state == ST_IDLE) ? rr_pick : cur;
    trig_vec          = '0;
    trig_vec[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rec_en     = 1'b0;
    rec_to     = 1'b0;
    rec_val    = '0;
    case (state)
      ST_IDLE: begin
        if (rr_found) state_next = ST_TRIG;
      end
      ST_TRIG: begin
        if (tick && us_cnt == TRIG_LAST) state_next = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          state_next = ST_MEASURE;
        end else if (tick && us_cnt == TMO_LAST) begin
          state_next = ST_HOLDOFF;
          rec_en     = 1'b1;
          rec_to     = 1'b1;
          rec_val    = '1;
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          state_next = ST_HOLDOFF;
          rec_en     = 1'b1;
          rec_val    = us_cnt;
        end else if (tick && us_cnt == TMO_LAST) begin
          state_next = ST_HOLDOFF;
          rec_en     = 1'b1;
          rec_to     = 1'b1;
          rec_val    = '1;
        end
      end
      ST_HOLDOFF: begin
        if (tick && us_cnt == HOLD_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: synchronizers, us timer / width counter, selection and result file.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta <= '0;
      echo_sync <= '0;
      echo_prev <= '0;
      us_cnt    <= '0;
      cur       <= '0;
      last_idx  <= IDX_W'(N_SENSORS - 1);
      trigger   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      valid     <= '0;
      tmo       <= '0;
      for (int i = 0; i < int'(N_SENSORS); i++) result[i] <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;

      if (restart)                  us_cnt <= '0;
      else if (tick && us_cnt != '1) us_cnt <= us_cnt + 1'b1;

      if (state == ST_IDLE && rr_found) begin
        cur      <= rr_pick;
        last_idx <= rr_pick;
      end

      trigger <= (state_next == ST_TRIG) ? trig_vec : '0;
      done    <= rec_en;
      busy    <= (state_next != ST_IDLE);

      if (rec_en) begin
        result[cur] <= rec_val;
        valid[cur]  <= 1'b1;
        tmo[cur]    <= rec_to;
      end
    end
  end

  always_comb begin
    rd_data   = '0;
    rd_status = '0;
    for (int i = 0; i < int'(N_SENSORS); i++) begin
      if (i < 4 && rd_sel == 2'(i)) begin
        rd_data   = result[i];
        rd_status = {tmo[i], valid[i]};
      end
    end
  end

endmodule

// File: tb/tb_ultra_ping_scheduler.sv
// Directed + randomized bench for ultra_ping_scheduler with a reference model of ping outcomes.
module tb_ultra_ping_scheduler;

  localparam int unsigned N       = 4;
  localparam int unsigned CLK_HZ  = 4_000_000;
  localparam int unsigned DIV     = CLK_HZ / 1_000_000;
  localparam int unsigned TRIG_US = 10;
  localparam int unsigned TMO_US  = 100;
  localparam int unsigned HOLD_US = 50;

  localparam int MODE_ECHO  = 0;
  localparam int MODE_NONE  = 1;
  localparam int MODE_STUCK = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] enable_mask;
  logic [N-1:0] echo;
  logic [N-1:0] trigger;
  logic [1:0]   rd_sel;
  logic [15:0]  rd_data;
  logic [1:0]   rd_status;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int multi_hot = 0;
  int last_served = N - 1;

  always #5 clk = ~clk;

  ultra_ping_scheduler #(
    .N_SENSORS       (N),
    .CLK_HZ          (CLK_HZ),
    .TRIG_US         (TRIG_US),
    .ECHO_TIMEOUT_US (TMO_US),
    .HOLDOFF_US      (HOLD_US)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_mask (enable_mask),
    .echo        (echo),
    .trigger     (trigger),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .rd_status   (rd_status),
    .done        (done),
    .busy        (busy)
  );

  always @(negedge clk) if ($countones(trigger) > 1) multi_hot++;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Next enabled sensor after the last one served, in plain modular arithmetic.
  function automatic int rr_next(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic read_port(input int idx, output int data, output int status);
    rd_sel = 2'(idx);
    #1;
    data   = int'(rd_data);
    status = int'(rd_status);
  endtask

  // One full ping: watch trigger, play the echo, check result, done and holdoff.
  task automatic run_ping(input int exp_idx, input int mode, input int dly, input int wid,
                          input logic [N-1:0] next_mask, input bit clr_mid);
    int cyc, hi, got, data, status, noise;
    cyc = 0;
    while (trigger == '0 && cyc < 3000) begin @(negedge clk); cyc++; end
    check_rng("trig_seen", cyc, 0, 2999);
    got = -1;
    for (int i = 0; i < N; i++) if (trigger[i]) got = i;
    check("trig_idx", got, exp_idx);
    if (mode == MODE_STUCK) echo[exp_idx] = 1'b1;
    hi = 0;
    while (trigger != '0 && hi < 1000) begin @(negedge clk); hi++; end
    check("trig_width", hi, TRIG_US * DIV);
    last_served = exp_idx;
    noise = (exp_idx + 2) % N;
    cyc = 0;
    if (mode == MODE_ECHO) begin
      repeat (dly * DIV) @(negedge clk);
      echo[exp_idx] = 1'b1;
      echo[noise]   = 1'b1;
      if (clr_mid) begin
        repeat (3 * DIV) @(negedge clk);
        enable_mask = '0;
        repeat ((wid - 3) * DIV) @(negedge clk);
      end else begin
        repeat (wid * DIV) @(negedge clk);
      end
      echo[exp_idx] = 1'b0;
      echo[noise]   = 1'b0;
    end
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    check("done_seen", int'(done), 1);
    if (mode != MODE_ECHO) check_rng("timeout_wait", cyc, TMO_US * DIV - 1, TMO_US * DIV + 1);
    read_port(exp_idx, data, status);
    if (mode == MODE_ECHO) begin
      check_rng("echo_width", data, wid - 1, wid + 1);
      check("status_ok", status, 1);
    end else begin
      check("timeout_data", data, 32'hFFFF);
      check("status_tmo", status, 3);
    end
    echo[exp_idx] = 1'b0;
    enable_mask = next_mask;
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    cyc = 1;
    while (busy && cyc < 1000) begin
      check("holdoff_trig", int'(trigger), 0);
      @(negedge clk);
      cyc++;
    end
    check_rng("holdoff_len", cyc, HOLD_US * DIV - 1, HOLD_US * DIV + 1);
  endtask

  initial begin
    int data, status, nxt, cyc;
    reset = 1'b1;
    enable_mask = '0;
    echo = '0;
    rd_sel = '0;
    repeat (5) @(negedge clk);
    check("rst_trigger", int'(trigger), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    for (int i = 0; i < N; i++) begin
      read_port(i, data, status);
      check("rst_data", data, 0);
      check("rst_status", status, 0);
    end
    reset = 1'b0;

    // Single sensor with a 37 us echo, then a silent sensor, then a stuck-high echo.
    enable_mask = 4'b0001;
    run_ping(0, MODE_ECHO, 5, 37, 4'b0010, 1'b0);
    run_ping(1, MODE_NONE, 0, 0, 4'b0100, 1'b0);
    run_ping(2, MODE_STUCK, 0, 0, 4'b1011, 1'b0);

    // Round robin over 0,1,3 with random echoes.
    for (int p = 0; p < 6; p++) begin
      nxt = rr_next(last_served, 4'b1011);
      run_ping(nxt, MODE_ECHO, int'($urandom_range(1, 20)), int'($urandom_range(5, 60)),
               4'b1011, 1'b0);
    end

    // Mask cleared mid-measurement: ping completes, scheduler then idles.
    nxt = rr_next(last_served, 4'b1011);
    run_ping(nxt, MODE_ECHO, 2, 30, 4'b0000, 1'b1);
    repeat (200) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_trigger", int'(trigger), 0);

    // Reset in the middle of TRIG.
    enable_mask = 4'b1111;
    cyc = 0;
    while (trigger == '0 && cyc < 100) begin @(negedge clk); cyc++; end
    check_rng("pre_rst_trig", cyc, 0, 99);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_trigger", int'(trigger), 0);
    check("mid_rst_busy", int'(busy), 0);
    for (int i = 0; i < N; i++) begin
      read_port(i, data, status);
      check("mid_rst_status", status, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    last_served = N - 1;
    run_ping(rr_next(last_served, 4'b1111), MODE_ECHO, 3, 20, 4'b0000, 1'b0);

    check("trigger_onehot", multi_hot, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
